// File: rtl/itr_pkg.sv
// -----------------------------------------------------------------------------
// itr_pkg
// Shared definitions for the vectored interrupt controller:
//   - state_e  : controller FSM states (IDLE, REQ)
//   - IDW/DPW  : channel-id and nesting-depth widths for the default build
//   - vec_addr : vector address of a channel, before truncation to the
//                instruction address width
// -----------------------------------------------------------------------------
package itr_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    localparam int NITR_DEF = 4;
    localparam int NEST_DEF = 2;
    localparam int IDW      = $clog2(NITR_DEF);
    localparam int DPW      = $clog2(NEST_DEF + 1);

    // Full-width vector address; the caller truncates to its address width.
    function automatic logic [31:0] vec_addr(input int unsigned base,
                                             input int unsigned stp,
                                             input int unsigned id);
        return 32'(base + id * stp);
    endfunction

endpackage

// File: rtl/itr_ctrl_prio_enc.sv
// -----------------------------------------------------------------------------
// prio_enc
// Combinational lowest-index priority encoder.
//   req_i [NITR] : request vector, bit 0 has the highest priority
//   vld_o        : at least one request bit is set
//   idx_o [IW]   : index of the lowest set bit (0 when vld_o is low)
// -----------------------------------------------------------------------------
module prio_enc #(
    parameter int NITR = 4,
    parameter int IW   = $clog2(NITR)
) (
    input  logic [NITR-1:0] req_i,
    output logic            vld_o,
    output logic [IW-1:0]   idx_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        for (int i = NITR - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                vld_o = 1'b1;
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/itr_ctrl.sv
// -----------------------------------------------------------------------------
// itr_ctrl
// Multi-channel vectored interrupt controller with fixed priority and nested
// service. Each channel passes a SYNC-flop synchroniser and an edge-detect
// register, sets its pending bit on an event, and is offered to the core when
// enabled, while nesting depth allows, and while it outranks the channel on top
// of the in-service stack.
//   clk, rst      : clock, asynchronous active-high reset
//   irq [NITR]    : asynchronous interrupt sources
//   cfg_wr        : load cfg_mask into the enable mask
//   cfg_mask      : enable mask, 1 = enabled
//   itr_ack       : core took the vector (pulse)
//   reti          : core returned from the ISR (pulse)
//   itr           : interrupt request to the core
//   itr_addr      : vector address of the requested channel
//   itr_id        : requested channel
//   pend          : pending bits
//   depth         : current nesting depth
//   err           : sticky protocol error (stray ack or reti)
// -----------------------------------------------------------------------------
module itr_ctrl
    import itr_pkg::*;
#(
    parameter int              NITR   = NITR_DEF,
    parameter int              MINSTW = 9,
    parameter int              VECBAS = 1,
    parameter int              VECSTP = 2,
    parameter int              NEST   = NEST_DEF,
    parameter logic [NITR-1:0] EDGE   = {NITR{1'b1}},
    parameter int              SYNC   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NITR-1:0]            irq,
    input  logic                       cfg_wr,
    input  logic [NITR-1:0]            cfg_mask,
    input  logic                       itr_ack,
    input  logic                       reti,
    output logic                       itr,
    output logic [MINSTW-1:0]          itr_addr,
    output logic [$clog2(NITR)-1:0]    itr_id,
    output logic [NITR-1:0]            pend,
    output logic [$clog2(NEST+1)-1:0]  depth,
    output logic                       err
);

    localparam int IW = $clog2(NITR);
    localparam int DW = $clog2(NEST + 1);

    logic [SYNC-1:0][NITR-1:0] sync_q;
    logic [NITR-1:0]           dly_q, evt_q, evt_d, s_out;
    logic [NITR-1:0]           mask_q, pend_q, pend_d, elig;
    logic [IW-1:0]             stk_q [NEST];
    logic [IW-1:0]             stk_d [NEST];
    logic [IW-1:0]             top, id_q, id_d, sel_idx;
    logic [DW-1:0]             depth_q, dep;
    logic [MINSTW-1:0]         addr_q, addr_d;
    logic                      itr_q, itr_d, err_q, err_d, sel_vld, ack_ok;
    state_e                    state_q, state_d;

    // Input path: synchroniser, then the edge-detect register compares the
    // synchronised level with its previous value; the event itself is
    // registered before it reaches the pending bits.
    assign s_out = sync_q[SYNC-1];
    assign evt_d = (s_out & ~dly_q & EDGE) | (s_out & ~EDGE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= '0;
            evt_q  <= '0;
            mask_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], irq};
            dly_q  <= s_out;
            evt_q  <= evt_d;
            if (cfg_wr) begin
                mask_q <= cfg_mask;
            end
        end
    end

    // Top-of-stack id; only meaningful when depth_q is non-zero.
    always_comb begin
        top = '0;
        for (int k = 0; k < NEST; k++) begin
            if (int'(depth_q) == k + 1) begin
                top = stk_q[k];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NITR; i++) begin
            elig[i] = pend_q[i] & mask_q[i] & (int'(depth_q) < NEST) &
                      ((depth_q == '0) | (IW'(i) < top));
        end
    end

    prio_enc #(.NITR(NITR), .IW(IW)) u_prio (
        .req_i (elig),
        .vld_o (sel_vld),
        .idx_o (sel_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            itr_q   <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            pend_q  <= '0;
            depth_q <= '0;
            for (int k = 0; k < NEST; k++) begin
                stk_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            itr_q   <= itr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            depth_q <= dep;
            stk_q   <= stk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        itr_d   = itr_q;
        id_d    = id_q;
        addr_d  = addr_q;
        err_d   = err_q;
        pend_d  = pend_q;
        stk_d   = stk_q;
        dep     = depth_q;
        ack_ok  = itr_ack && (state_q == ST_REQ);

        // Pop before push so a simultaneous reti/ack replaces the top entry.
        if (reti) begin
            if (depth_q == '0) begin
                err_d = 1'b1;
            end else begin
                dep = depth_q - 1'b1;
            end
        end
        if (itr_ack && !ack_ok) begin
            err_d = 1'b1;
        end
        // Depth cannot reach NEST while in REQ, so the push index stays in range.
        if (ack_ok) begin
            for (int k = 0; k < NEST; k++) begin
                if (int'(dep) == k) begin
                    stk_d[k] = id_q;
                end
            end
            dep = dep + 1'b1;
            for (int i = 0; i < NITR; i++) begin
                if (IW'(i) == id_q) begin
                    pend_d[i] = 1'b0;
                end
            end
        end
        // A new event wins over a same-cycle ack clear.
        pend_d = pend_d | evt_q;

        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    itr_d   = 1'b1;
                    id_d    = sel_idx;
                    addr_d  = MINSTW'(vec_addr(VECBAS, VECSTP, int'(sel_idx)));
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (itr_ack) begin
                    itr_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign itr      = itr_q;
    assign itr_addr = addr_q;
    assign itr_id   = id_q;
    assign pend     = pend_q;
    assign depth    = depth_q;
    assign err      = err_q;

endmodule

// File: tb/tb_itr_ctrl.sv
module tb_itr_ctrl;

    localparam int         NITR   = 4;
    localparam int         MINSTW = 9;
    localparam int         VECBAS = 1;
    localparam int         VECSTP = 2;
    localparam int         NEST   = 2;
    localparam int         SYNC   = 2;
    localparam logic [3:0] EDGE   = 4'b1101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] irq = '0;
    logic       cfg_wr = 1'b0;
    logic [3:0] cfg_mask = '0;
    logic       itr_ack = 1'b0;
    logic       reti = 1'b0;
    logic       itr;
    logic [8:0] itr_addr;
    logic [1:0] itr_id;
    logic [3:0] pend;
    logic [1:0] depth;
    logic       err;

    itr_ctrl #(
        .NITR(NITR), .MINSTW(MINSTW), .VECBAS(VECBAS), .VECSTP(VECSTP),
        .NEST(NEST), .EDGE(EDGE), .SYNC(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .irq(irq), .cfg_wr(cfg_wr), .cfg_mask(cfg_mask),
        .itr_ack(itr_ack), .reti(reti), .itr(itr), .itr_addr(itr_addr),
        .itr_id(itr_id), .pend(pend), .depth(depth), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: irq history as a queue (index k = value sampled k edges
    // ago), in-service stack as a queue, request as a flag.
    logic [3:0] hist[$];
    logic [3:0] m_pend, m_mask;
    int         m_stk[$];
    bit         m_req;
    int         m_id;
    logic [8:0] m_addr;
    bit         m_err;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic m_reset();
        hist.delete();
        for (int k = 0; k < SYNC + 3; k++) hist.push_back(4'b0);
        m_pend = '0; m_mask = '0; m_stk.delete();
        m_req = 1'b0; m_id = 0; m_addr = '0; m_err = 1'b0;
    endtask

    task automatic m_step();
        logic [3:0] ev;
        int  dep, top, nid, pre_id;
        bit  found, pre_req;
        hist.push_front(irq);
        void'(hist.pop_back());
        ev  = (hist[SYNC+1] & ~hist[SYNC+2] & EDGE) | (hist[SYNC+1] & ~EDGE);
        dep = m_stk.size();
        top = (dep > 0) ? m_stk[dep-1] : 0;
        found = 1'b0; nid = 0;
        for (int i = NITR - 1; i >= 0; i--)
            if (m_pend[i] && m_mask[i] && dep < NEST && (dep == 0 || i < top)) begin
                found = 1'b1; nid = i;
            end
        pre_req = m_req; pre_id = m_id;
        if (reti) begin
            if (dep == 0) m_err = 1'b1;
            else void'(m_stk.pop_back());
        end
        if (itr_ack) begin
            if (!pre_req) m_err = 1'b1;
            else begin
                m_stk.push_back(pre_id);
                m_pend[pre_id] = 1'b0;
            end
        end
        m_pend = m_pend | ev;
        if (pre_req) begin
            if (itr_ack) m_req = 1'b0;
        end else if (found) begin
            m_req = 1'b1; m_id = nid;
            m_addr = 9'(VECBAS + nid * VECSTP);
        end
        if (cfg_wr) m_mask = cfg_mask;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("itr",      32'(itr),      32'(m_req));
        chk("itr_addr", 32'(itr_addr), 32'(m_addr));
        chk("itr_id",   32'(itr_id),   32'(m_id));
        chk("pend",     32'(pend),     32'(m_pend));
        chk("depth",    32'(depth),    32'(m_stk.size()));
        chk("err",      32'(err),      32'(m_err));
    endtask

    // One clock: model steps at the edge, outputs checked 1 time unit later,
    // one-cycle pulse inputs dropped afterwards.
    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        check_all();
        cfg_wr = 1'b0; itr_ack = 1'b0; reti = 1'b0;
    endtask

    task automatic wait_itr(input int maxc, input string tag);
        int n = 0;
        while (!itr && n < maxc) begin
            tick();
            n++;
        end
        chk({tag, "_wait"}, 32'(itr), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        m_reset();
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Single edge channel, all enabled
        cfg_wr = 1'b1; cfg_mask = 4'b1111; tick();
        irq = 4'b0100; tick(); tick(); tick();
        irq = 4'b0000; tick(); tick();
        chk("s1_itr",  32'(itr),      32'd1);
        chk("s1_addr", 32'(itr_addr), 32'd5);
        chk("s1_id",   32'(itr_id),   32'd2);
        itr_ack = 1'b1; tick();
        chk("s1_pend2", 32'(pend[2]), 32'd0);
        chk("s1_depth", 32'(depth),   32'd1);
        chk("s1_itr0",  32'(itr),     32'd0);
        reti = 1'b1; tick();

        // Two channels together: priority, then held off by the stack top
        irq = 4'b1010; tick();
        irq = 4'b0000;
        wait_itr(10, "s2a");
        chk("s2_addr3", 32'(itr_addr), 32'd3);
        itr_ack = 1'b1; tick();
        repeat (6) tick();
        chk("s2_hold", 32'(itr), 32'd0);
        reti = 1'b1; tick();
        wait_itr(6, "s2b");
        chk("s2_addr7", 32'(itr_addr), 32'd7);
        itr_ack = 1'b1; tick();
        reti = 1'b1; tick();

        // Nesting up to the limit
        irq = 4'b0100; tick();
        irq = 4'b0000;
        wait_itr(10, "s3a");
        itr_ack = 1'b1; tick();
        irq = 4'b0001; tick();
        irq = 4'b0000;
        wait_itr(10, "s3b");
        chk("s3_addr1", 32'(itr_addr), 32'd1);
        itr_ack = 1'b1; tick();
        chk("s3_depth2", 32'(depth), 32'd2);
        irq = 4'b0001; tick();
        irq = 4'b0000;
        repeat (8) tick();
        chk("s3_pend0", 32'(pend[0]), 32'd1);
        chk("s3_noitr", 32'(itr),     32'd0);
        reti = 1'b1; tick();
        wait_itr(6, "s3c");
        chk("s3_id0", 32'(itr_id), 32'd0);
        itr_ack = 1'b1; tick();
        reti = 1'b1; tick();
        reti = 1'b1; tick();

        // Level channel held through ack
        irq = 4'b0010;
        wait_itr(10, "s4a");
        chk("s4_id1", 32'(itr_id), 32'd1);
        itr_ack = 1'b1; tick();
        tick();
        chk("s4_pend1", 32'(pend[1]), 32'd1);
        repeat (4) tick();
        chk("s4_hold", 32'(itr), 32'd0);
        reti = 1'b1; tick();
        wait_itr(6, "s4b");
        chk("s4_reid", 32'(itr_id), 32'd1);
        irq = 4'b0000;
        itr_ack = 1'b1; tick();
        reti = 1'b1; tick();
        do_reset();

        // Masked pending, then enabled
        irq = 4'b0001; tick();
        irq = 4'b0000;
        repeat (5) tick();
        chk("s5_pend0", 32'(pend[0]), 32'd1);
        chk("s5_masked", 32'(itr), 32'd0);
        cfg_wr = 1'b1; cfg_mask = 4'b0001; tick();
        tick();
        chk("s5_itr", 32'(itr), 32'd1);
        itr_ack = 1'b1; tick();
        reti = 1'b1; tick();

        // Stray reti sets sticky error
        reti = 1'b1; tick();
        chk("s6_err", 32'(err), 32'd1);
        repeat (3) tick();
        chk("s6_sticky", 32'(err), 32'd1);

        // Randomised traffic against the model
        for (int c = 0; c < 400; c++) begin
            irq      = 4'($urandom);
            cfg_wr   = ($urandom_range(0, 7) == 0);
            cfg_mask = 4'($urandom);
            itr_ack  = itr ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
            reti     = ($urandom_range(0, 9) == 0);
            tick();
        end
        irq = 4'b0000;

        // Asynchronous reset while a request is outstanding
        do_reset();
        cfg_wr = 1'b1; cfg_mask = 4'b1111; tick();
        irq = 4'b1000; tick();
        irq = 4'b0000;
        wait_itr(10, "s7");
        #2;
        do_reset();
        chk("s7_itr",  32'(itr),  32'd0);
        chk("s7_pend", 32'(pend), 32'd0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
